mult_seq: RTL
=============

// Module: mult_seq
// PURPOSE
//  Iterative shift-add multiplier: BITS_PER_CYCLE multiplier bits consumed per clock.
//  Signed/unsigned is selected per operation. Full product is split into high/low halves.
//  Handshake: valid/ready on both input and output.
//  Area-lean successor to the combinational multipliers. Sits in datapaths that can accept
//  a multi-cycle latency in exchange for no full-width array multiplier.
// PARAMETERS
//  INPUT_WIDTH     16  operand width W; must be >= 2
//  BITS_PER_CYCLE  1   multiplier bits retired per CALC cycle; must divide INPUT_WIDTH
//  (derived) ITERS = INPUT_WIDTH/BITS_PER_CYCLE
// PORTS
//  clk        in   1  single clock, rising edge
//  rst        in   1  asynchronous, active-high reset
//  in_valid   in   1  operands/mode valid
//  in_ready   out  1  block can accept an operation
//  is_signed  in   1  1: two's-complement operands; 0: unsigned (sampled with operands)
//  in0        in   W  multiplicand
//  in1        in   W  multiplier
//  out_valid  out  1  high/low hold a finished product
//  out_ready  in   1  consumer accepts product
//  high       out  W  product[2W-1:W]
//  low        out  W  product[W-1:0]
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; high=low=0.
//  All internal regs are cleared. An in-flight operation is discarded, with no output.
//  FSM: IDLE -> CALC -> DONE -> IDLE.
//  IDLE:
//   - in_ready=1.
//   - in_valid&in_ready at edge: capture is_signed, |in0|, |in1|, sign=in0[W-1]^in1[W-1]
//     (sign forced 0 when unsigned).
//   - Magnitudes use a W-bit unsigned value, so -2^(W-1) maps to 2^(W-1).
//   - Clear 2W accumulator, iteration count=ITERS-1, go to CALC.
//  CALC:
//   - in_ready=0.
//   - Each edge: acc += (mcand_mag * mplier_mag[BITS_PER_CYCLE-1:0]) << shift.
//   - The multiplier register shifts right by BITS_PER_CYCLE; count decrements.
//   - At the edge where count==0: {high,low} <= sign ? -acc_final : acc_final (2W-bit
//     two's-complement negate), then go to DONE.
//  DONE:
//   - out_valid=1; high/low stable.
//   - in_ready=0 (no new operation accepted while holding).
//   - out_ready=1 at edge -> IDLE, out_valid drops the next cycle.
//   - out_ready=0 -> hold indefinitely, with outputs unchanged.
//  Latency: accepting edge t -> out_valid high after edge t+ITERS.
//  Min issue interval: ITERS+2 cycles.
//  high/low are registered and change only on the final CALC edge or on reset.
//  They keep their last value in IDLE.
//  in0/in1/is_signed changing during CALC/DONE have no effect.
//  in_valid is ignored unless in_ready.
//  Zero operand still runs the full ITERS cycles (no early exit).
//  W-bit x W-bit unsigned result is always exact in 2W bits.
//  Signed (-2^(W-1))^2 = 2^(2W-2) is also exact.
// CONFIGURATION
//  MULT_SEQ_OVERFLOW_EN defined:
//   - Adds output port `overflow` (1 bit, reset 0), registered alongside high/low.
//   - overflow=1 when the product does not fit in W bits:
//     unsigned: high!=0; signed: high != {W{low[W-1]}}.
//  Not defined: the port and its logic do not exist; all other behaviour is identical.
// TESTING
//  T1 W=8, unsigned 255*255 -> high=0xFE low=0x01, out_valid 8 edges after accept.
//     With MULT_SEQ_OVERFLOW_EN: overflow=1.
//  T2 W=8, signed -3*5 (0xFD,0x05) -> high=0xFF low=0xF1; overflow=0.
//  T3 W=8, signed -128*-128 -> high=0x40 low=0x00; overflow=1. Unsigned 0x80*0x80 gives the same bits.
//  T4 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, high, low held; in_ready=0.
//     in_valid pulsed meanwhile is ignored. Release -> IDLE the next cycle.
//  T5 Assert rst 3 cycles into CALC -> in_ready=1, out_valid=0, high=low=0 immediately.
//     No stale output after release; next op (7*6) gives low=42.
//  T6 W=16, BITS_PER_CYCLE=4, signed 0x8000*0x7FFF -> {high,low}=0xC0008000.
//     out_valid 4 edges after accept. Back-to-back ops every 6 cycles.

Source files
------------

// File: rtl/mult_seq.sv
// mult_seq -- iterative shift-add multiplier.
//
// Each CALC cycle retires BITS_PER_CYCLE multiplier bits. The operation runs
// on magnitudes, and the sign is applied once on the final edge. The 2W-bit
// product is presented as high/low behind a valid/ready output handshake.
// No new operation is accepted until the product has been taken.
//
// Optional feature: define MULT_SEQ_OVERFLOW_EN to add the `overflow` output.
// It flags a product that does not fit in W bits.
//
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   in_valid / in_ready   operand handshake
//   is_signed, in0, in1   mode, multiplicand, multiplier (sampled on accept)
//   out_valid / out_ready product handshake
//   high, low             product[2W-1:W], product[W-1:0]
//   overflow              (MULT_SEQ_OVERFLOW_EN only) product exceeds W bits

module mult_seq #(
    parameter int INPUT_WIDTH    = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   is_signed,
    input  logic [INPUT_WIDTH-1:0] in0,
    input  logic [INPUT_WIDTH-1:0] in1,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INPUT_WIDTH-1:0] high,
    output logic [INPUT_WIDTH-1:0] low
`ifdef MULT_SEQ_OVERFLOW_EN
    ,
    output logic                   overflow
`endif
);

    localparam int W     = INPUT_WIDTH;
    localparam int B     = BITS_PER_CYCLE;
    localparam int ITERS = W / B;
    localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q;
    logic            in_ready_q, out_valid_q;
    logic            signed_q, sign_q;
    logic [2*W-1:0]  mcand_q;       // multiplicand magnitude, pre-shifted into place
    logic [W-1:0]    mplier_q;      // multiplier magnitude, consumed from the LSB
    logic [2*W-1:0]  acc_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    high_q, low_q;
    logic            ovf_q;

    logic [W-1:0]    mag0_d, mag1_d;
    logic [2*W-1:0]  part_d, acc_d, prod_d;
    logic            ovf_d;

    // W-bit unsigned magnitudes: -2^(W-1) negates to itself, which reads as 2^(W-1).
    always_comb begin
        mag0_d = (is_signed && in0[W-1]) ? -in0 : in0;
        mag1_d = (is_signed && in1[W-1]) ? -in1 : in1;
    end

    // One partial product per cycle, built from BITS_PER_CYCLE shifted copies of
    // the multiplicand, so no full-width array multiplier is needed.
    always_comb begin
        part_d = '0;
        for (int i = 0; i < B; i++) begin
            if (mplier_q[i]) part_d = part_d + (mcand_q << i);
        end
        acc_d  = acc_q + part_d;
        prod_d = sign_q ? -acc_d : acc_d;
        if (signed_q) ovf_d = (prod_d[2*W-1:W] != {W{prod_d[W-1]}});
        else          ovf_d = (prod_d[2*W-1:W] != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            signed_q    <= 1'b0;
            sign_q      <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            high_q      <= '0;
            low_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        signed_q   <= is_signed;
                        sign_q     <= is_signed & (in0[W-1] ^ in1[W-1]);
                        mcand_q    <= {{W{1'b0}}, mag0_d};
                        mplier_q   <= mag1_d;
                        acc_q      <= '0;
                        cnt_q      <= CW'(ITERS - 1);
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << B;
                    mplier_q <= mplier_q >> B;
                    cnt_q    <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        high_q      <= prod_d[2*W-1:W];
                        low_q       <= prod_d[W-1:0];
                        ovf_q       <= ovf_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign high      = high_q;
    assign low       = low_q;
`ifdef MULT_SEQ_OVERFLOW_EN
    assign overflow  = ovf_q;
`else
    // The overflow flag is only exported when the feature is enabled.
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule
